// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl: OTTER 5-stage hazard unit (forwarding, load-use stall,
// redirect flush, dmem freeze) with a scoreboard of in-flight destinations.
// Ports: CLK/RST (async, active-high); Decode fields D_*; EX_REDIRECT;
// DMEM_WAIT; PC_WRITE, *_EN, *_FLUSH, FWD_A/B; STALL_CYCLES, FLUSH_COUNT.
module otter_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       D_RS1,
  input  logic [4:0]       D_RS2,
  input  logic             D_USES_RS1,
  input  logic             D_USES_RS2,
  input  logic [4:0]       D_RD,
  input  logic             D_REG_WRITE,
  input  logic             D_MEM_READ,
  input  logic             EX_REDIRECT,
  input  logic             DMEM_WAIT,
  output logic             PC_WRITE,
  output logic             FD_EN,
  output logic             DE_EN,
  output logic             EM_EN,
  output logic             MW_EN,
  output logic             FD_FLUSH,
  output logic             DE_FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] FREEZE = 1'b1;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ex_slot_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } wr_slot_t;

  ex_slot_t   ex_q, ex_d;
  wr_slot_t   mem_q, mem_d;
  wr_slot_t   wb_q, wb_d;
  logic [0:0] state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic ex_we, mem_we, wb_we;
  logic load_use;
  logic c_wait, c_redir, c_lu;
  logic frz_entry, frz_hold;
  logic stall_inc, flush_inc;

  // x0 is never a real producer
  assign ex_we  = ex_q.we  & (|ex_q.rd);
  assign mem_we = mem_q.we & (|mem_q.rd);
  assign wb_we  = wb_q.we  & (|wb_q.rd);

  always_comb begin
    FWD_A = 2'b00;
    if (ex_q.u1 && mem_we && mem_q.rd == ex_q.rs1)
      FWD_A = 2'b01;
    else if (ex_q.u1 && wb_we && wb_q.rd == ex_q.rs1)
      FWD_A = 2'b10;
  end

  always_comb begin
    FWD_B = 2'b00;
    if (ex_q.u2 && mem_we && mem_q.rd == ex_q.rs2)
      FWD_B = 2'b01;
    else if (ex_q.u2 && wb_we && wb_q.rd == ex_q.rs2)
      FWD_B = 2'b10;
  end

  assign load_use = ex_q.ld & ex_we &
    ((D_USES_RS1 & (D_RS1 == ex_q.rd)) |
     (D_USES_RS2 & (D_RS2 == ex_q.rd)));

  always_comb begin
    c_wait   = 1'b0;
    c_redir  = 1'b0;
    c_lu     = 1'b0;
    PC_WRITE = 1'b1;
    FD_EN    = 1'b1;
    DE_EN    = 1'b1;
    EM_EN    = 1'b1;
    MW_EN    = 1'b1;
    FD_FLUSH = 1'b0;
    DE_FLUSH = 1'b0;
    priority case (1'b1)
      DMEM_WAIT: begin
        c_wait   = 1'b1;
        PC_WRITE = 1'b0;
        FD_EN    = 1'b0;
        DE_EN    = 1'b0;
        EM_EN    = 1'b0;
        MW_EN    = 1'b0;
      end
      EX_REDIRECT: begin
        c_redir  = 1'b1;
        FD_FLUSH = 1'b1;
        DE_FLUSH = 1'b1;
      end
      load_use: begin
        c_lu     = 1'b1;
        PC_WRITE = 1'b0;
        FD_EN    = 1'b0;
        DE_FLUSH = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!c_wait) begin
      wb_d  = mem_q;
      mem_d = '{rd: ex_q.rd, we: ex_q.we};
      if (c_redir || c_lu)
        ex_d = '0;
      else
        ex_d = '{rd:  D_RD,
                 we:  D_REG_WRITE,
                 ld:  D_MEM_READ,
                 rs1: D_RS1,
                 rs2: D_RS2,
                 u1:  D_USES_RS1,
                 u2:  D_USES_RS2};
    end
  end

  assign state_d = DMEM_WAIT ? FREEZE : RUN;

  // a freeze counts every cycle: first cycle on entry, rest while held
  assign frz_entry = DMEM_WAIT & (state_q == RUN);
  assign frz_hold  = DMEM_WAIT & (state_q == FREEZE);
  assign stall_inc = frz_entry | frz_hold | c_lu;
  assign flush_inc = c_redir;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (flush_inc && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign STALL_CYCLES = stall_q;
  assign FLUSH_COUNT  = flush_q;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// tb_otter_hazard_ctrl: directed + random bench for otter_hazard_ctrl,
// checked against an instruction-queue model of the pipeline.
module tb_otter_hazard_ctrl;

  localparam int W   = 4;
  localparam int SAT = (1 << W) - 1;

  logic CLK;
  logic RST;
  logic [4:0] D_RS1, D_RS2, D_RD;
  logic D_USES_RS1, D_USES_RS2, D_REG_WRITE, D_MEM_READ;
  logic EX_REDIRECT, DMEM_WAIT;
  logic PC_WRITE, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH;
  logic [1:0] FWD_A, FWD_B;
  logic [W-1:0] STALL_CYCLES, FLUSH_COUNT;

  otter_hazard_ctrl #(.CNT_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .D_RS1(D_RS1), .D_RS2(D_RS2),
    .D_USES_RS1(D_USES_RS1), .D_USES_RS2(D_USES_RS2),
    .D_RD(D_RD), .D_REG_WRITE(D_REG_WRITE), .D_MEM_READ(D_MEM_READ),
    .EX_REDIRECT(EX_REDIRECT), .DMEM_WAIT(DMEM_WAIT),
    .PC_WRITE(PC_WRITE), .FD_EN(FD_EN), .DE_EN(DE_EN),
    .EM_EN(EM_EN), .MW_EN(MW_EN),
    .FD_FLUSH(FD_FLUSH), .DE_FLUSH(DE_FLUSH),
    .FWD_A(FWD_A), .FWD_B(FWD_B),
    .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ins_t;

  localparam ins_t NOP = '0;

  // pipe[0] = instruction in EX, [1] = MEM, [2] = WB
  ins_t pipe[$];
  ins_t cur;
  bit   redir, wt;
  int   st_m, fl_m;
  int   n_vec, n_err;

  assign D_RD        = cur.rd;
  assign D_REG_WRITE = cur.we;
  assign D_MEM_READ  = cur.ld;
  assign D_RS1       = cur.rs1;
  assign D_RS2       = cur.rs2;
  assign D_USES_RS1  = cur.u1;
  assign D_USES_RS2  = cur.u2;
  assign EX_REDIRECT = redir;
  assign DMEM_WAIT   = wt;

  function automatic ins_t mk(int rd, bit we, bit ld,
                              int rs1, bit u1, int rs2, bit u2);
    ins_t i;
    i.rd  = 5'(rd);
    i.we  = we;
    i.ld  = ld;
    i.rs1 = 5'(rs1);
    i.rs2 = 5'(rs2);
    i.u1  = u1;
    i.u2  = u2;
    return i;
  endfunction

  function automatic bit writes(ins_t i);
    return i.we && i.rd != 0;
  endfunction

  // nearest older in-flight producer wins
  function automatic logic [1:0] src(logic [4:0] rs, logic u);
    if (!u) return 2'd0;
    for (int k = 1; k <= 2; k++)
      if (writes(pipe[k]) && pipe[k].rd == rs)
        return 2'(k);
    return 2'd0;
  endfunction

  function automatic bit lu();
    return writes(pipe[0]) && pipe[0].ld &&
      ((cur.u1 && cur.rs1 == pipe[0].rd) ||
       (cur.u2 && cur.rs2 == pipe[0].rd));
  endfunction

  function automatic int sat_inc(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < 3; k++) pipe.push_back(NOP);
    st_m = 0;
    fl_m = 0;
  endtask

  task automatic advance(ins_t i);
    void'(pipe.pop_back());
    pipe.push_front(i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [6:0] e;
    if (wt)          e = 7'b0000000;
    else if (redir)  e = 7'b1111111;
    else if (lu())   e = 7'b0011101;
    else             e = 7'b1111100;
    chk({tag, ".ctrl"}, 32'({PC_WRITE, FD_EN, DE_EN, EM_EN, MW_EN,
                             FD_FLUSH, DE_FLUSH}), 32'(e));
    chk({tag, ".fwda"}, 32'(FWD_A), 32'(src(pipe[0].rs1, pipe[0].u1)));
    chk({tag, ".fwdb"}, 32'(FWD_B), 32'(src(pipe[0].rs2, pipe[0].u2)));
    chk({tag, ".stall"}, 32'(STALL_CYCLES), 32'(st_m));
    chk({tag, ".flush"}, 32'(FLUSH_COUNT), 32'(fl_m));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else if (wt) st_m = sat_inc(st_m);
    else if (redir) begin
      fl_m = sat_inc(fl_m);
      advance(NOP);
    end else if (lu()) begin
      st_m = sat_inc(st_m);
      advance(NOP);
    end else advance(cur);
    #1;
  endtask

  task automatic drive(ins_t i, bit r, bit w);
    cur   = i;
    redir = r;
    wt    = w;
    #3;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin
      drive(NOP, 0, 0);
      check_all("drain");
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cur   = NOP;
    redir = 0;
    wt    = 0;
    RST   = 1'b0;
    model_reset();
    #1 RST = 1'b1;
    #2;
    check_all("reset");
    chk("reset.pc", 32'(PC_WRITE), 32'd1);
    chk("reset.fwd", 32'({FWD_A, FWD_B}), 32'd0);
    tick();
    RST = 1'b0;

    // back-to-back and distance-2 RAW
    drive(mk(5, 1, 0, 1, 1, 2, 1), 0, 0); check_all("add"); tick();
    drive(mk(6, 1, 0, 5, 1, 3, 1), 0, 0); check_all("sub"); tick();
    drive(mk(7, 1, 0, 4, 1, 5, 1), 0, 0); check_all("or");
    chk("raw_d1", 32'(FWD_A), 32'd1);
    tick();
    drive(NOP, 0, 0); check_all("n1");
    chk("raw_d2", 32'(FWD_B), 32'd2);
    tick();

    // x0 producers
    drain();
    drive(mk(0, 1, 1, 1, 1, 2, 1), 0, 0); check_all("lw_x0"); tick();
    drive(mk(12, 1, 0, 0, 1, 0, 1), 0, 0); check_all("use_x0");
    chk("x0_lu", 32'(PC_WRITE), 32'd1);
    tick();
    drive(NOP, 0, 0); check_all("x0_n");
    chk("x0_fwd", 32'({FWD_A, FWD_B}), 32'd0);
    tick();

    // load-use
    drain();
    drive(mk(7, 1, 1, 1, 1, 0, 0), 0, 0); check_all("lw"); tick();
    drive(mk(8, 1, 0, 7, 1, 2, 1), 0, 0); check_all("lu");
    chk("lu_pc", 32'(PC_WRITE), 32'd0);
    chk("lu_fd", 32'(FD_EN), 32'd0);
    chk("lu_def", 32'(DE_FLUSH), 32'd1);
    tick();
    chk("lu_stall", 32'(STALL_CYCLES), 32'd1);
    drive(mk(8, 1, 0, 7, 1, 2, 1), 0, 0); check_all("lu2");
    chk("lu_pc2", 32'(PC_WRITE), 32'd1);
    tick();
    drive(NOP, 0, 0); check_all("lu3");
    chk("lu_fwd", 32'(FWD_A), 32'd2);
    tick();

    // redirect overriding load-use
    drain();
    drive(mk(9, 1, 1, 1, 1, 0, 0), 0, 0); check_all("lw9"); tick();
    drive(mk(10, 1, 0, 9, 1, 9, 1), 1, 0); check_all("rdlu");
    chk("rd_ctl", 32'({PC_WRITE, FD_FLUSH, DE_FLUSH}), 32'd7);
    tick();
    chk("rd_cnt", 32'(FLUSH_COUNT), 32'd1);
    chk("rd_st", 32'(STALL_CYCLES), 32'd1);
    drive(NOP, 0, 0); check_all("rd_n");
    chk("rd_fwd", 32'({FWD_A, FWD_B}), 32'd0);
    tick();

    // memory freeze with a pending MEM match
    drain();
    drive(mk(10, 1, 0, 1, 1, 2, 1), 0, 0); check_all("f_add"); tick();
    drive(mk(11, 1, 0, 10, 1, 3, 1), 0, 0); check_all("f_sub"); tick();
    for (int k = 0; k < 3; k++) begin
      drive(mk(13, 1, 0, 11, 1, 10, 1), 0, 1); check_all("frz");
      chk("frz_en", 32'({FD_EN, DE_EN, EM_EN, MW_EN}), 32'd0);
      chk("frz_fwd", 32'(FWD_A), 32'd1);
      tick();
    end
    chk("frz_st", 32'(STALL_CYCLES), 32'd4);
    drive(NOP, 0, 0); check_all("frz_4");
    chk("frz_fwd4", 32'(FWD_A), 32'd1);
    tick();
    drive(NOP, 0, 0); check_all("frz_5");
    chk("frz_adv", 32'(FWD_A), 32'd0);
    tick();

    // saturation
    for (int k = 0; k < 14; k++) begin
      drive(NOP, 0, 1); check_all("sat"); tick();
    end
    chk("sat_st", 32'(STALL_CYCLES), 32'(SAT));
    drive(NOP, 0, 1); check_all("sat2"); tick();
    chk("sat_hold", 32'(STALL_CYCLES), 32'(SAT));

    // async reset mid-freeze, between edges
    drive(mk(4, 1, 1, 1, 1, 2, 1), 0, 1);
    RST = 1'b1;
    #1;
    model_reset();
    chk("arst_st", 32'(STALL_CYCLES), 32'd0);
    chk("arst_fl", 32'(FLUSH_COUNT), 32'd0);
    check_all("arst");
    RST = 1'b0;
    wt  = 0;
    #1;
    check_all("arst2");
    tick();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(mk($urandom_range(0, 7), 1'($urandom), 1'($urandom),
               $urandom_range(0, 7), 1'($urandom),
               $urandom_range(0, 7), 1'($urandom)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
      check_all("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/otter_hazard_ctrl.md
# otter_hazard_ctrl

Pipeline hazard controller for the 5-stage OTTER pipeline (Fetch, Decode, Execute, Memory, Writeback). It tracks in-flight destination registers in an internal scoreboard that mirrors the pipeline registers. From that scoreboard it drives the ALU operand forwarding selects, load-use stalls, branch/jump flushes and data-memory freezes. It sits beside the FD/DE/EM/MW pipeline registers and owns their enables and flushes, plus PC_WRITE on the PC.

## Interface
- CNT_W, default 32: width of the performance counters.
- CLK  in  1  clock. All state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- D_RS1, D_RS2  in  5 each  source registers of the instruction in Decode (FD.IR[19:15], FD.IR[24:20]).
- D_USES_RS1, D_USES_RS2  in  1 each  the Decode instruction reads that source.
- D_RD  in  5  destination register of the Decode instruction.
- D_REG_WRITE  in  1  the Decode instruction writes D_RD.
- D_MEM_READ  in  1  the Decode instruction is a load.
- EX_REDIRECT  in  1  taken branch, JAL or JALR resolved in Execute this cycle.
- DMEM_WAIT  in  1  data memory not ready. Freezes the whole pipeline.
- PC_WRITE  out  1  PC update enable.
- FD_EN, DE_EN, EM_EN, MW_EN  out  1 each  pipeline register load enables.
- FD_FLUSH, DE_FLUSH  out  1 each  load a bubble (NOP, all write/read controls 0) into FD or DE at the next edge.
- FWD_A, FWD_B  out  2 each  Execute operand source: 00 = register file, 01 = EM.ALUResult, 10 = writeback data (wdata).
- STALL_CYCLES, FLUSH_COUNT  out  CNT_W each  saturating performance counters.

## Operation
- **Scoreboard.** The scoreboard holds three slots:
  - EX slot: {rd, we, ld, rs1, rs2, u1, u2}.
  - MEM slot: {rd, we}.
  - WB slot: {rd, we}.
- A slot with rd = 0 is treated as we = 0. x0 never forwards and never stalls.
- **Forwarding.** FWD_A is computed combinationally from the EX slot:
  - 01 if u1 and mem.we and mem.rd == ex.rs1.
  - else 10 if u1 and wb.we and wb.rd == ex.rs1.
  - else 00.
  - FWD_B is the same using rs2/u2. The MEM match has priority over the WB match.
- **load_use** = ex.ld & ex.we & ((D_USES_RS1 & D_RS1 == ex.rd) | (D_USES_RS2 & D_RS2 == ex.rd)).
- **Control priority** (exactly one case applies each cycle):
  1. DMEM_WAIT: PC_WRITE = 0, all four EN = 0, both FLUSH = 0.
  2. EX_REDIRECT: PC_WRITE = 1, all EN = 1, FD_FLUSH = 1, DE_FLUSH = 1. A redirect overrides load_use.
  3. load_use: PC_WRITE = 0, FD_EN = 0, DE_EN = 1, DE_FLUSH = 1, EM_EN = MW_EN = 1.
  4. Otherwise: PC_WRITE = 1, all EN = 1, both FLUSH = 0.
- **FSM.** Two states, RUN and FREEZE.
  - The state is registered: FREEZE when DMEM_WAIT was sampled high at the last edge, else RUN.
  - It is used only to detect freeze entry for the counters. The outputs above are not gated by it.
- **Scoreboard update** at posedge, when not in case 1:
  - wb <= mem, then mem <= {ex.rd, ex.we}.
  - ex <= bubble (all 0) in cases 2 and 3.
  - Otherwise ex <= the Decode fields {D_RD, D_REG_WRITE, D_MEM_READ, D_RS1, D_RS2, D_USES_RS1, D_USES_RS2}.
  - In case 1 all slots hold.
- **Counters:**
  - STALL_CYCLES += 1 on every edge sampled in case 1 or case 3.
  - FLUSH_COUNT += 1 on every edge sampled in case 2.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous): all scoreboard slots = 0, state = RUN, counters = 0.
  - Resulting outputs during and immediately after reset: PC_WRITE = 1, all EN = 1, FLUSH = 0, FWD_A = FWD_B = 00.
- Control outputs are combinational, same cycle as the inputs. Scoreboard effects appear one edge later.
- Load-use penalty is exactly 1 cycle. The dependent instruction then sees FWD = 10 from the load in WB.
- Redirect penalty is 2 bubbles (FD and DE). FLUSH is asserted for exactly 1 cycle per EX_REDIRECT cycle.
- DMEM_WAIT held for N cycles freezes for exactly N cycles. Outputs resume case 2-4 evaluation in the cycle DMEM_WAIT drops.
- RST asserted mid-stall or mid-freeze clears everything immediately. No pending stall or flush survives reset.

## Test plan
- **Reset.** Assert RST with DMEM_WAIT = 0 -> PC_WRITE = 1, all EN = 1, FD_FLUSH = DE_FLUSH = 0, FWD_A = FWD_B = 00, STALL_CYCLES = FLUSH_COUNT = 0.
- **Back-to-back RAW.** `add x5,x1,x2` then `sub x6,x5,x3` -> FWD_A = 01 in the cycle `sub` is in EX. Distance-2 dependency (`or x7,x4,x5` two instructions after the `add`) -> FWD_B = 10. Writes to x0 never produce FWD ≠ 00.
- **Load-use.** `lw x7,0(x1)` then `add x8,x7,x2` -> one cycle with PC_WRITE = 0, FD_EN = 0, DE_FLUSH = 1, STALL_CYCLES = 1. Then FWD_A = 10 when `add` reaches EX.
- **Redirect with load-use.** EX_REDIRECT = 1 in the same cycle as load_use -> PC_WRITE = 1, FD_FLUSH = DE_FLUSH = 1, FLUSH_COUNT = 1, STALL_CYCLES unchanged. Next cycle FWD = 00.
- **Memory freeze.** DMEM_WAIT = 1 for 3 cycles while a MEM match is pending -> all EN = 0 for 3 cycles, FWD_A stays 01, STALL_CYCLES += 3. Pipeline advances on the 4th edge.
- **Saturation and async reset.** Preload the counters near all-ones and hold DMEM_WAIT -> STALL_CYCLES sticks at 2^CNT_W − 1. Pulse RST between clock edges -> counters 0 immediately.
